// File: rtl/button_conditioner.sv
// ============================================================================
// Module   : button_conditioner
// Purpose  : Per-channel button conditioning. Each raw pin is synchronized,
//            debounced by a four-state FSM and turned into a registered
//            level, one-cycle press/release pulses and an optional
//            auto-repeat pulse train while the button is held.
// Ports    : CLK          - sole clock, rising edge
//            RST          - synchronous active-low reset
//            BTN_RAW      - asynchronous bouncing pins, bit i = channel i
//            BTN_LEVEL    - debounced level per channel (registered)
//            BTN_PRESS    - one-cycle pulse on accepted rising level
//            BTN_RELEASE  - one-cycle pulse on accepted falling level
//            BTN_REPEAT   - one-cycle auto-repeat pulse while held
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] BTN_RAW,
  output logic [N_BTN-1:0] BTN_LEVEL,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_RELEASE,
  output logic [N_BTN-1:0] BTN_REPEAT
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  localparam logic            REPEAT_EN = (REPEAT_DELAY > 0);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_M1  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_M1 = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0]       sync_q;
    logic             sync_w;
    state_e           state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;  // first repeat already issued
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             rep_q, rep_d;
    logic             rep_due_w;

    assign sync_w = sync_q[1];

    always_ff @(posedge CLK) begin
      if (!RST) begin
        sync_q      <= '0;
        state_q     <= IDLE;
        db_cnt_q    <= '0;
        rep_cnt_q   <= '0;
        rep_first_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        rel_q       <= 1'b0;
        rep_q       <= 1'b0;
      end else begin
        sync_q      <= {sync_q[0], BTN_RAW[i]};
        state_q     <= state_d;
        db_cnt_q    <= db_cnt_d;
        rep_cnt_q   <= rep_cnt_d;
        rep_first_q <= rep_first_d;
        level_q     <= level_d;
        press_q     <= press_d;
        rel_q       <= rel_d;
        rep_q       <= rep_d;
      end
    end

    always_comb begin
      state_d     = state_q;
      db_cnt_d    = db_cnt_q;
      rep_cnt_d   = rep_cnt_q;
      rep_first_d = rep_first_q;
      level_d     = level_q;
      press_d     = 1'b0;
      rel_d       = 1'b0;
      rep_d       = 1'b0;
      rep_due_w   = 1'b0;

      // Repeat timer runs through HELD and RELEASE_CHK so that a release
      // glitch does not shift the cadence; it restarts after every pulse.
      if (state_q == HELD || state_q == RELEASE_CHK) begin
        if (rep_first_q ? (rep_cnt_q == PERIOD_M1) : (rep_cnt_q == DELAY_M1)) begin
          rep_due_w   = 1'b1;
          rep_cnt_d   = '0;
          rep_first_d = 1'b1;
        end else if (rep_cnt_q != {REP_W{1'b1}}) begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end

      unique case (state_q)
        IDLE: begin
          db_cnt_d    = '0;
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
          if (sync_w) begin
            state_d  = PRESS_CHK;
            db_cnt_d = DB_W'(1);
          end
        end
        PRESS_CHK: begin
          if (!sync_w) begin
            state_d  = IDLE;
            db_cnt_d = '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_d     = HELD;
            db_cnt_d    = '0;
            level_d     = 1'b1;
            press_d     = 1'b1;
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end
        HELD: begin
          rep_d = rep_due_w & REPEAT_EN;
          if (!sync_w) begin
            state_d  = RELEASE_CHK;
            db_cnt_d = DB_W'(1);
          end
        end
        RELEASE_CHK: begin
          // Repeats falling due here are dropped (rep_d stays 0).
          if (sync_w) begin
            state_d  = HELD;
            db_cnt_d = '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_d     = IDLE;
            db_cnt_d    = '0;
            level_d     = 1'b0;
            rel_d       = 1'b1;
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign BTN_LEVEL[i]   = level_q;
    assign BTN_PRESS[i]   = press_q;
    assign BTN_RELEASE[i] = rel_q;
    assign BTN_REPEAT[i]  = rep_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Self-checking bench for button_conditioner. A behavioural model
//            tracks accepted level, run length of disagreeing samples and
//            the press edge index, and derives expected outputs per edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;

  localparam int N   = 2;
  localparam int DB  = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [N-1:0] BTN_RAW = '0;
  logic [N-1:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_REPEAT;

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN_RAW(BTN_RAW),
    .BTN_LEVEL(BTN_LEVEL), .BTN_PRESS(BTN_PRESS),
    .BTN_RELEASE(BTN_RELEASE), .BTN_REPEAT(BTN_REPEAT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [N-1:0] m_s1 = '0, m_s2 = '0;
  logic [N-1:0] m_lvl = '0, m_press = '0, m_rel = '0, m_rep = '0;
  int           m_run [N];
  int           m_press_e [N];
  int           edge_n = 0;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_n, obs, exp);
    end
  endtask

  // One rising edge worth of behaviour, using the inputs present at the edge.
  task automatic model_step();
    edge_n++;
    if (!RST) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      m_press = '0; m_rel = '0; m_rep = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        logic s;
        logic was_held;
        int   dt;
        s = m_s2[i];
        was_held = m_lvl[i] && (m_run[i] == 0);
        m_press[i] = 1'b0; m_rel[i] = 1'b0; m_rep[i] = 1'b0;
        if (s != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_lvl[i] = s;
            m_run[i] = 0;
            if (s) begin
              m_press[i]   = 1'b1;
              m_press_e[i] = edge_n;
            end else begin
              m_rel[i] = 1'b1;
            end
          end
        end else begin
          m_run[i] = 0;
        end
        dt = edge_n - m_press_e[i] - DLY;
        if (DLY > 0 && was_held && dt >= 0 && (dt % PER) == 0) m_rep[i] = 1'b1;
      end
      m_s2 = m_s1;
      m_s1 = BTN_RAW;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check_eq("outs", {BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_REPEAT},
                     {m_lvl, m_press, m_rel, m_rep});
  endtask

  task automatic do_reset();
    RST = 1'b0;
    BTN_RAW = '0;
    tick(); tick();
    RST = 1'b1;
    tick(); tick(); tick();
  endtask

  int hold [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_press_e[i] = 0; hold[i] = 0;
    end
    #1;

    // Reset state
    RST = 1'b0;
    tick(); tick(); tick();
    check_eq("reset_outs", {BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_REPEAT}, 8'h00);
    RST = 1'b1;
    tick(); tick();

    // Clean press, auto-repeat, release. k = edge index relative to first sample.
    BTN_RAW = 2'b01;
    for (int k = 0; k <= 32; k++) begin
      tick();
      if (k == 4)  check_eq("press_early", {6'd0, BTN_PRESS}, 8'h00);
      if (k == 5)  check_eq("press_edge", {4'd0, BTN_LEVEL, BTN_PRESS}, 8'h05);
      if (k == 6)  check_eq("press_one_cycle", {6'd0, BTN_PRESS}, 8'h00);
      if (k == 15) check_eq("repeat_first", {6'd0, BTN_REPEAT}, 8'h01);
      if (k == 16) check_eq("repeat_gap", {6'd0, BTN_REPEAT}, 8'h00);
      if (k == 18) check_eq("repeat_second", {6'd0, BTN_REPEAT}, 8'h01);
      if (k == 21) check_eq("repeat_third", {6'd0, BTN_REPEAT}, 8'h01);
      if (k == 27) check_eq("repeat_suppressed", {6'd0, BTN_REPEAT, BTN_RELEASE}, 8'h00);
      if (k == 28) check_eq("release_edge", {4'd0, BTN_LEVEL, BTN_RELEASE}, 8'h01);
      if (k == 30) check_eq("no_repeat_after_release", {6'd0, BTN_REPEAT}, 8'h00);
      if (k == 22) BTN_RAW = 2'b00;
    end

    // Reset mid-debounce with button held: re-debounced from scratch.
    do_reset();
    BTN_RAW = 2'b01;
    tick(); tick(); tick(); tick();
    RST = 1'b0;
    tick();
    check_eq("reset_mid_count", {BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_REPEAT}, 8'h00);
    RST = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      tick();
      if (j == 4) check_eq("post_reset_early", {4'd0, BTN_LEVEL, BTN_PRESS}, 8'h00);
      if (j == 5) check_eq("post_reset_press", {4'd0, BTN_LEVEL, BTN_PRESS}, 8'h05);
    end

    // Concurrent press, staggered release.
    BTN_RAW = 2'b00;
    for (int j = 0; j < 12; j++) tick();
    do_reset();
    BTN_RAW = 2'b11;
    for (int k = 0; k <= 18; k++) begin
      tick();
      if (k == 5)  check_eq("press_both", {6'd0, BTN_PRESS}, 8'h03);
      if (k == 9)  BTN_RAW = 2'b10;
      if (k == 10) BTN_RAW = 2'b00;
      if (k == 14) check_eq("release_none_yet", {6'd0, BTN_RELEASE}, 8'h00);
      if (k == 15) check_eq("release_ch0", {6'd0, BTN_RELEASE}, 8'h01);
      if (k == 16) check_eq("release_ch1", {6'd0, BTN_RELEASE}, 8'h02);
    end

    // Randomized bouncing on both channels with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          BTN_RAW[i] = ~BTN_RAW[i];
          hold[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                : int'($urandom_range(5, 40));
        end
        hold[i]--;
      end
      RST = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, default 2: number of independent button channels; legal range 1..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: consecutive synchronized samples required to accept a level change; legal range 2..2^20.
REQ-003 Parameter REPEAT_DELAY, default 25000000: HELD cycles before the first auto-repeat pulse; 0 disables auto-repeat.
REQ-004 Parameter REPEAT_PERIOD, default 5000000: cycles between subsequent repeat pulses; legal range 1..2^24.
REQ-005 CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 RST  input  1  synchronous, active-low reset.
REQ-007 BTN_RAW  input  N_BTN  asynchronous, bouncing button pins; bit i is channel i.
REQ-008 BTN_LEVEL  output  N_BTN  debounced level per channel, registered.
REQ-009 BTN_PRESS  output  N_BTN  one-cycle pulse on accepted rising level.
REQ-010 BTN_RELEASE  output  N_BTN  one-cycle pulse on accepted falling level.
REQ-011 BTN_REPEAT  output  N_BTN  one-cycle auto-repeat pulse while held.

Function
REQ-012 Each BTN_RAW bit SHALL pass a two-flop synchronizer before any other logic; channels SHALL be fully independent.
REQ-013 Each channel SHALL run an FSM with states IDLE, PRESS_CHK, HELD, RELEASE_CHK.
REQ-014 IDLE -> PRESS_CHK when the synchronized input is 1; PRESS_CHK -> IDLE when it returns to 0 before the count completes (count cleared).
REQ-015 PRESS_CHK -> HELD when the synchronized input has been 1 for DEBOUNCE_CYCLES consecutive samples; BTN_LEVEL set and BTN_PRESS pulsed on that same edge.
REQ-016 HELD -> RELEASE_CHK on synchronized 0; RELEASE_CHK -> HELD on 1 before completion, with the count cleared, no pulses, and the repeat timer not reset.
REQ-017 RELEASE_CHK -> IDLE after DEBOUNCE_CYCLES consecutive 0 samples; BTN_LEVEL cleared and BTN_RELEASE pulsed on that edge.
REQ-018 Latency: raw level first sampled at edge t and held stable -> BTN_LEVEL and the pulse registered at edge t+DEBOUNCE_CYCLES+1.
REQ-019 Shorter glitches (fewer than DEBOUNCE_CYCLES consecutive synchronized samples) SHALL produce no output change.
REQ-020 With REPEAT_DELAY>0, the repeat timer starts on entry to HELD; first BTN_REPEAT at REPEAT_DELAY cycles after the BTN_PRESS edge, then every REPEAT_PERIOD cycles.
REQ-021 The repeat timer continues counting in RELEASE_CHK; repeat pulses falling due there SHALL be suppressed.
REQ-022 Entry to IDLE SHALL clear the repeat timer; BTN_REPEAT SHALL never coincide with BTN_PRESS or BTN_RELEASE on a channel.
REQ-023 Counter widths SHALL be derived with clog2 of the respective parameter; counters saturate, never wrap.
REQ-024 Simultaneous events on different channels SHALL be reported on the same cycle without interaction.
REQ-025 Every pulse output SHALL be exactly one cycle wide.

Reset
REQ-026 RST=0 at a rising edge SHALL force all FSMs to IDLE, all counters, synchronizer flops and outputs to 0, overriding any in-progress count.
REQ-027 A button held through reset release SHALL be re-debounced from IDLE and produce BTN_PRESS after DEBOUNCE_CYCLES+1 further edges; no BTN_RELEASE SHALL be emitted by reset.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_BTN=2)
REQ-028 Clean press: BTN_RAW[0] 0->1 sampled at edge 10 -> BTN_LEVEL[0]=1 and BTN_PRESS[0] high for one cycle after edge 15.
REQ-029 Bounce: BTN_RAW[0] high for 3 cycles, low for 1 cycle, then high steadily from edge 20 -> no pulse before edge 25; single BTN_PRESS after edge 25.
REQ-030 Auto-repeat: hold from press pulse at edge 15 -> BTN_REPEAT at edges 25, 28, 31; release -> BTN_RELEASE after 5 edges, with no further repeats.
REQ-031 Release glitch: while HELD, 2-cycle low glitch -> no BTN_RELEASE; BTN_LEVEL stays 1; repeat cadence unchanged.
REQ-032 Reset mid-count: RST=0 during PRESS_CHK (count 3) with button still held -> all outputs 0; after RST=1, BTN_PRESS appears DEBOUNCE_CYCLES+1 edges later.
REQ-033 Concurrency: both channels pressed on the same edge -> BTN_PRESS=2'b11 on the same cycle; staggered release by 1 cycle -> BTN_RELEASE bits 1 cycle apart.
